// File: rtl/tlc_light_monitor_pkg.sv
// Purpose: shared lamp encodings, fault codes, phase-group masks and helpers for the light monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tlc_light_monitor_pkg;

    localparam int NUM_LIGHTS = 6;

    typedef enum logic [1:0] {
        LAMP_GREEN   = 2'd0,
        LAMP_YELLOW  = 2'd1,
        LAMP_RED     = 2'd2,
        LAMP_INVALID = 2'd3
    } lamp_e;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_CONFLICT     = 3'd1,
        FC_ILLEGAL      = 3'd2,
        FC_SHORT_GREEN  = 3'd3,
        FC_SHORT_YELLOW = 3'd4,
        FC_INVALID      = 3'd5,
        FC_STALL        = 3'd6
    } fault_code_e;

    typedef enum logic [0:0] {
        MON_RUN   = 1'b0,
        MON_FAULT = 1'b1
    } mon_state_e;

    // Bit i of a light vector corresponds to TL(i+1).
    localparam logic [NUM_LIGHTS-1:0] GRP_A_MASK = 6'b100001;  // TL1, TL6
    localparam logic [NUM_LIGHTS-1:0] GRP_B_MASK = 6'b001010;  // TL2, TL4
    localparam logic [NUM_LIGHTS-1:0] GRP_C_MASK = 6'b010100;  // TL3, TL5

    // Lowest-numbered flagged light as 1..6, or 0 when nothing is flagged.
    function automatic logic [2:0] lowest_light(input logic [NUM_LIGHTS-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_LIGHTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tlc_light_monitor_checker.sv
// Purpose: per-light tracker: previous sample, dwell counter, transition / short-dwell / invalid flags.
// Latency: flags are combinational from the current input; state updates on each rising edge.
// Backpressure: none; samples every cycle.
module tlc_light_checker
    import tlc_light_monitor_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 4,
    parameter int CNT_W      = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] lamp_i,
    output logic       changed_o,
    output logic       illegal_o,
    output logic       short_green_o,
    output logic       short_yellow_o,
    output logic       invalid_o,
    output logic       active_o
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GREEN_LIM = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] YEL_LIM   = CNT_W'(MIN_YELLOW);

    logic [1:0]       prev_q;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             legal_step;

    // Classify the current sample against the previous one and compute the next dwell.
    always_comb begin
        changed_o      = (lamp_i != prev_q);
        legal_step     = ((prev_q == LAMP_RED)    && (lamp_i == LAMP_GREEN))  ||
                         ((prev_q == LAMP_GREEN)  && (lamp_i == LAMP_YELLOW)) ||
                         ((prev_q == LAMP_YELLOW) && (lamp_i == LAMP_RED));
        illegal_o      = changed_o && !legal_step;
        short_green_o  = (prev_q == LAMP_GREEN)  && (lamp_i == LAMP_YELLOW) && (dwell_q < GREEN_LIM);
        short_yellow_o = (prev_q == LAMP_YELLOW) && (lamp_i == LAMP_RED)    && (dwell_q < YEL_LIM);
        invalid_o      = (lamp_i == LAMP_INVALID);
        active_o       = (lamp_i != LAMP_RED);
        if (changed_o) begin
            dwell_d = CNT_ONE;
        end else if (dwell_q != CNT_MAX) begin
            dwell_d = dwell_q + CNT_ONE;
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Track the lamp; reset to red with a saturated dwell so the first transitions never look short.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= LAMP_RED;
            dwell_q <= CNT_MAX;
        end else begin
            prev_q  <= lamp_i;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/tlc_light_monitor.sv
// Purpose: safety monitor on TL1..TL6; latches the first violation and requests flashing-red fallback.
// Latency: violation on inputs before edge N is latched at edge N (1 cycle).
// Backpressure: none; inputs sampled every cycle, fault held until fault_clr or reset.
module tlc_light_monitor
    import tlc_light_monitor_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 4,
    parameter int MAX_STALL  = 256,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] TL1,
    input  logic [1:0] TL2,
    input  logic [1:0] TL3,
    input  logic [1:0] TL4,
    input  logic [1:0] TL5,
    input  logic [1:0] TL6,
    input  logic       fault_clr,
    output logic       flash,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] fault_light,
    output logic [7:0] fault_count
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL - 1);

    logic [1:0]            lamp [NUM_LIGHTS];
    logic [NUM_LIGHTS-1:0] changed, illegal, short_green, short_yellow, invalid, active;

    logic [2:0]            grp_act;
    logic                  conflict;
    logic [NUM_LIGHTS-1:0] own_mask;
    logic [2:0]            conflict_light;

    logic [CNT_W-1:0]      stall_q, stall_d;
    logic                  stall_viol;

    fault_code_e           viol_code;
    logic [2:0]            viol_light;
    logic                  viol;
    logic                  capture;
    logic                  clear;

    mon_state_e            state_q, state_d;
    fault_code_e           code_q, code_d;
    logic [2:0]            light_q, light_d;
    logic [7:0]            count_q, count_d;

    assign lamp[0] = TL1;
    assign lamp[1] = TL2;
    assign lamp[2] = TL3;
    assign lamp[3] = TL4;
    assign lamp[4] = TL5;
    assign lamp[5] = TL6;

    for (genvar g = 0; g < NUM_LIGHTS; g++) begin : g_chk
        tlc_light_checker #(
            .MIN_GREEN (MIN_GREEN),
            .MIN_YELLOW(MIN_YELLOW),
            .CNT_W     (CNT_W)
        ) u_chk (
            .clk_i         (clk),
            .rst_ni        (reset),
            .lamp_i        (lamp[g]),
            .changed_o     (changed[g]),
            .illegal_o     (illegal[g]),
            .short_green_o (short_green[g]),
            .short_yellow_o(short_yellow[g]),
            .invalid_o     (invalid[g]),
            .active_o      (active[g])
        );
    end

    // Conflict: two or more phase groups active; blame the first non-red light outside the lowest active group.
    always_comb begin
        grp_act  = {|(active & GRP_C_MASK), |(active & GRP_B_MASK), |(active & GRP_A_MASK)};
        conflict = (grp_act[0] & grp_act[1]) | (grp_act[0] & grp_act[2]) | (grp_act[1] & grp_act[2]);
        if (grp_act[0]) begin
            own_mask = GRP_A_MASK;
        end else if (grp_act[1]) begin
            own_mask = GRP_B_MASK;
        end else begin
            own_mask = GRP_C_MASK;
        end
        conflict_light = lowest_light(active & ~own_mask);
    end

    // Stall counter: restarts on any lamp change or on clearing a latched fault, otherwise counts up saturating.
    always_comb begin
        stall_viol = !(|changed) && (stall_q >= STALL_LIM);
        if (clear || (fault_clr && state_q == MON_FAULT)) begin
            stall_d = '0;
        end else if (|changed) begin
            stall_d = '0;
        end else if (stall_q != CNT_MAX) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // Priority encode simultaneous violations: invalid > conflict > illegal > short yellow > short green > stall.
    always_comb begin
        viol_code  = FC_NONE;
        viol_light = 3'd0;
        if (|invalid) begin
            viol_code  = FC_INVALID;
            viol_light = lowest_light(invalid);
        end else if (conflict) begin
            viol_code  = FC_CONFLICT;
            viol_light = conflict_light;
        end else if (|illegal) begin
            viol_code  = FC_ILLEGAL;
            viol_light = lowest_light(illegal);
        end else if (|short_yellow) begin
            viol_code  = FC_SHORT_YELLOW;
            viol_light = lowest_light(short_yellow);
        end else if (|short_green) begin
            viol_code  = FC_SHORT_GREEN;
            viol_light = lowest_light(short_green);
        end else if (stall_viol) begin
            viol_code  = FC_STALL;
            viol_light = 3'd0;
        end
        viol    = (viol_code != FC_NONE);
        capture = viol && ((state_q == MON_RUN) || fault_clr);
        clear   = 1'b0;
    end

    // Monitor state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MON_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: latch on any violation; a clear only returns to run when no new violation is present.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MON_RUN:   if (viol) state_d = MON_FAULT;
            MON_FAULT: if (fault_clr && !viol) state_d = MON_RUN;
            default:   state_d = MON_RUN;
        endcase
    end

    // Outputs decoded from state: flash mirrors the latched fault.
    always_comb begin
        fault = (state_q == MON_FAULT);
        flash = (state_q == MON_FAULT);
    end

    // Fault record next-state: capture wins over clear; count bumps on every capture, saturating.
    always_comb begin
        code_d  = code_q;
        light_d = light_q;
        count_d = count_q;
        if (capture) begin
            code_d  = viol_code;
            light_d = viol_light;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end else if (fault_clr && state_q == MON_FAULT) begin
            code_d  = FC_NONE;
            light_d = 3'd0;
        end
    end

    // Fault record and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q  <= FC_NONE;
            light_q <= 3'd0;
            count_q <= 8'd0;
            stall_q <= '0;
        end else begin
            code_q  <= code_d;
            light_q <= light_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign fault_code  = code_q;
    assign fault_light = light_q;
    assign fault_count = count_q;

endmodule

// File: tb/tb_tlc_light_monitor.sv
module tb_tlc_light_monitor;

    localparam logic [1:0] G = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] R = 2'd2;
    localparam logic [1:0] X = 2'd3;

    typedef logic [5:0][1:0] tl_vec_t;

    typedef struct {
        tl_vec_t    tl;
        logic       clr;
        logic       exp_fault;
        logic [2:0] exp_code;
        logic [2:0] exp_light;
        logic [7:0] exp_count;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] TL1 = R, TL2 = R, TL3 = R, TL4 = R, TL5 = R, TL6 = R;
    logic       fault_clr = 1'b0;
    logic       flash, fault;
    logic [2:0] fault_code, fault_light;
    logic [7:0] fault_count;

    int checks = 0;
    int errors = 0;

    vec_t vecs [10];

    tlc_light_monitor #(
        .MIN_GREEN (8),
        .MIN_YELLOW(4),
        .MAX_STALL (16),
        .CNT_W     (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .TL1        (TL1),
        .TL2        (TL2),
        .TL3        (TL3),
        .TL4        (TL4),
        .TL5        (TL5),
        .TL6        (TL6),
        .fault_clr  (fault_clr),
        .flash      (flash),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_light(fault_light),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    function automatic tl_vec_t lamps(input logic [1:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int f, input int code, input int light, input int count);
        chk({name, "_fault"}, int'(fault), f);
        chk({name, "_flash"}, int'(flash), f);
        chk({name, "_code"},  int'(fault_code), code);
        chk({name, "_light"}, int'(fault_light), light);
        chk({name, "_count"}, int'(fault_count), count);
    endtask

    // Drive one sample, let one rising edge pass, and return 1 time unit after it.
    task automatic apply(input tl_vec_t tl, input logic clr);
        TL1 = tl[0]; TL2 = tl[1]; TL3 = tl[2];
        TL4 = tl[3]; TL5 = tl[4]; TL6 = tl[5];
        fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fault_clr = 1'b0;
        TL1 = R; TL2 = R; TL3 = R; TL4 = R; TL5 = R; TL6 = R;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        tl_vec_t t;
        logic seen;
        int   ph, grp, w;

        vecs[0] = '{lamps(G, G, R, R, R, R), 1'b0, 1'b1, 3'd1, 3'd2, 8'd1};
        vecs[1] = '{lamps(R, R, R, R, R, R), 1'b0, 1'b1, 3'd1, 3'd2, 8'd1};
        vecs[2] = '{lamps(R, R, R, R, R, R), 1'b1, 1'b0, 3'd0, 3'd0, 8'd1};
        vecs[3] = '{lamps(R, R, G, G, R, R), 1'b0, 1'b1, 3'd1, 3'd3, 8'd2};
        vecs[4] = '{lamps(G, R, R, G, R, R), 1'b1, 1'b1, 3'd1, 3'd4, 8'd3};
        vecs[5] = '{lamps(R, R, R, R, R, R), 1'b0, 1'b1, 3'd1, 3'd4, 8'd3};
        vecs[6] = '{lamps(R, R, R, R, R, R), 1'b1, 1'b0, 3'd0, 3'd0, 8'd3};
        vecs[7] = '{lamps(R, R, R, R, G, R), 1'b0, 1'b0, 3'd0, 3'd0, 8'd3};
        vecs[8] = '{lamps(R, X, R, R, R, R), 1'b0, 1'b1, 3'd5, 3'd2, 8'd4};
        vecs[9] = '{lamps(G, G, R, R, R, R), 1'b0, 1'b1, 3'd5, 3'd2, 8'd4};

        // Reset state while reset is held low.
        #7;
        chk_all("reset", 0, 0, 0, 0);

        // Legal A/B/C rotation: green 8, yellow 4, then red.
        do_reset();
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            ph  = c % 36;
            grp = ph / 12;
            w   = ph % 12;
            t   = lamps(R, R, R, R, R, R);
            if (grp == 0) begin
                t[0] = (w < 8) ? G : Y; t[5] = (w < 8) ? G : Y;
            end else if (grp == 1) begin
                t[1] = (w < 8) ? G : Y; t[3] = (w < 8) ? G : Y;
            end else begin
                t[2] = (w < 8) ? G : Y; t[4] = (w < 8) ? G : Y;
            end
            apply(t, 1'b0);
            if (fault) seen = 1'b1;
        end
        chk("rotation_fault_seen", int'(seen), 0);
        chk("rotation_count", int'(fault_count), 0);

        // Table: conflicts, clear, set-wins-over-clear, invalid priority, freeze.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].tl, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].exp_fault), int'(vecs[i].exp_code),
                    int'(vecs[i].exp_light), int'(vecs[i].exp_count));
        end

        // Short green: TL1 green for 3 cycles then yellow.
        do_reset();
        repeat (3) apply(lamps(G, R, R, R, R, R), 1'b0);
        chk("sg_pre_fault", int'(fault), 0);
        apply(lamps(Y, R, R, R, R, R), 1'b0);
        chk_all("short_green", 1, 3, 1, 1);

        // Short yellow: TL3 green 10, yellow 2, then red.
        do_reset();
        repeat (10) apply(lamps(R, R, G, R, R, R), 1'b0);
        repeat (2)  apply(lamps(R, R, Y, R, R, R), 1'b0);
        chk("sy_pre_fault", int'(fault), 0);
        apply(lamps(R, R, R, R, R, R), 1'b0);
        chk_all("short_yellow", 1, 4, 3, 1);

        // Stall: static inputs after reset fault on the 16th edge.
        do_reset();
        repeat (15) apply(lamps(R, R, R, R, R, R), 1'b0);
        chk("stall_edge15_fault", int'(fault), 0);
        apply(lamps(R, R, R, R, R, R), 1'b0);
        chk_all("stall_edge16", 1, 6, 0, 1);

        // Clear with a legal change present.
        apply(lamps(G, R, R, R, R, R), 1'b1);
        chk_all("clr_legal", 0, 0, 0, 1);

        // Conflict appears (clear has nothing to clear), then clear held against a persisting conflict.
        apply(lamps(G, G, R, R, R, R), 1'b1);
        chk_all("conflict_after_clr", 1, 1, 2, 2);
        apply(lamps(G, G, R, R, R, R), 1'b1);
        chk_all("clr_vs_conflict", 1, 1, 2, 3);

        // Asynchronous reset mid-cycle drops every output before the next edge.
        fault_clr = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlc_light_monitor.md
Name: tlc_light_monitor

Overview:
- Safety monitor on the receiving end of the traffic light controller's TL1..TL6 outputs.
- Samples all six lamp codes every clock and checks them for:
  - conflicting phases
  - illegal colour sequences
  - short green/yellow dwell
  - invalid codes
  - controller stall
- On the first violation it latches a fault code and the offending light, and asserts flash, which forces the lamp drivers into flashing-red fallback.

Parameters:
- MIN_GREEN, 8: minimum cycles a light must hold green before going yellow.
- MIN_YELLOW, 4: minimum cycles a light must hold yellow before going red.
- MAX_STALL, 256: cycles with no change on any light before a stall fault.
- CNT_W, 10: width of dwell and stall counters (saturating); 2^CNT_W-1 must be >= MAX_STALL.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- TL1..TL6  in  2 each  lamp codes: 0=green, 1=yellow, 2=red, 3=invalid
- fault_clr  in  1  synchronous single-cycle fault clear
- flash  out  1  fallback request; equals the latched fault
- fault  out  1  fault latched
- fault_code  out  3  0 none, 1 conflict, 2 illegal transition, 3 short green, 4 short yellow, 5 invalid code, 6 stall
- fault_light  out  3  1..6 = offending light; 0 for stall or no fault
- fault_count  out  8  saturating count of faults latched since reset

Behaviour:
- Reset (async, reset=0): all outputs 0; fault_count 0; stall counter 0.
  - Previous-sample registers = red (2) for all lights.
  - Dwell counters saturated (2^CNT_W-1), so the first transitions are never flagged short.
- Phase groups: A={TL1,TL6}, B={TL2,TL4}, C={TL3,TL5}. A group is active if any member is non-red.
- Per light, each edge, current input vs previous sample:
  - No change: dwell <= sat(dwell+1).
  - Change: dwell <= 1.
  - Legal changes: R->G, G->Y, Y->R. Any other change is illegal (code 2).
  - G->Y with dwell < MIN_GREEN is short green (code 3).
  - Y->R with dwell < MIN_YELLOW is short yellow (code 4).
  - Current input == 3 is an invalid code (code 5), checked every cycle.
- Conflict (code 1): two or more groups active in the same sample.
  - Reported light = lowest-numbered non-red light outside the lowest-lettered active group.
- Stall (code 6):
  - Counter resets to 0 on any change on any light, otherwise increments (saturating).
  - Fault when the counter reaches MAX_STALL.
- Priority for simultaneous violations: 5 > 1 > 2 > 4 > 3 > 6.
  - Within one code, the lowest-numbered light wins.
- Latency: a violation present on inputs before edge N sets fault/flash/code/light at edge N (1 cycle).
- Latching:
  - Once fault=1, fault_code/fault_light freeze and new violations are ignored.
  - Previous-sample and dwell registers keep tracking the inputs.
- fault_count increments by 1 on each 0->1 latch of fault; it saturates at 255 and is cleared only by reset.
- fault_clr:
  - Clears fault, flash, fault_code, fault_light and the stall counter at the next edge.
  - If a violation is present in the same cycle, the new fault latches instead (set wins) and fault_count increments.
- fault_clr while no fault is latched: no effect.
- Reset asserted mid-fault: outputs drop to 0 immediately (asynchronously), regardless of clk.

Decomposition:
- Shared package holds:
  - lamp encodings GREEN=0, YELLOW=1, RED=2, INVALID=3
  - fault code constants 0..6
  - group membership constants
- One sub-module, tlc_light_checker, instantiated six times.
  - Contains: previous-sample register, dwell counter, transition/short-dwell/invalid flags.
  - Outputs: changed, illegal, short_green, short_yellow, invalid, active.
- Top level handles: conflict decode, stall counter, priority encode, latch, fault_count.

Test Plan:
- Legal rotation: A green 8 / yellow 4 / red, then B, then C, repeated for 300 cycles, with MAX_STALL=256 -> fault stays 0, fault_count=0.
- TL1=0 and TL2=0 in the same cycle (others red) -> after next edge fault=1, flash=1, fault_code=1, fault_light=2.
- TL3 green 10 cycles, yellow 2 cycles, then red -> fault_code=4, fault_light=3, one edge after red is applied.
- Simultaneous faults: TL5 green->red directly and TL2=3 in the same cycle -> fault_code=5, fault_light=2 (priority); a following conflict leaves code/light unchanged.
- MAX_STALL=16, inputs held static after reset -> fault at the 16th edge, fault_code=6, fault_light=0.
- fault_clr pulse with legal inputs -> fault=0, code=0, fault_count stays 1.
  - Then fault_clr coincident with a conflict -> fault stays 1 and fault_count=2.
  - Then reset=0 mid-cycle -> all outputs 0 before the next clk edge.
